// File: rtl/ddr3_dfi_responder_if.sv
// DFI command, write-data and read-data signals between a DDR3 controller and its PHY/DRAM stand-in.
// The master modport is the controller side; the slave modport is the responder.
interface ddr3_dfi_responder_if;
  logic [14:0] dfi_address_i;
  logic [2:0]  dfi_bank_i;
  logic        dfi_cs_n_i;
  logic        dfi_ras_n_i;
  logic        dfi_cas_n_i;
  logic        dfi_we_n_i;
  logic        dfi_cke_i;
  logic        dfi_reset_n_i;
  logic        dfi_odt_i;
  logic [31:0] dfi_wrdata_i;
  logic        dfi_wrdata_en_i;
  logic [3:0]  dfi_wrdata_mask_i;
  logic        dfi_rddata_en_i;
  logic [31:0] dfi_rddata_o;
  logic        dfi_rddata_valid_o;
  logic [1:0]  dfi_rddata_dnv_o;

  modport master (
    output dfi_address_i, dfi_bank_i, dfi_cs_n_i, dfi_ras_n_i, dfi_cas_n_i, dfi_we_n_i,
           dfi_cke_i, dfi_reset_n_i, dfi_odt_i, dfi_wrdata_i, dfi_wrdata_en_i,
           dfi_wrdata_mask_i, dfi_rddata_en_i,
    input  dfi_rddata_o, dfi_rddata_valid_o, dfi_rddata_dnv_o
  );

  modport slave (
    input  dfi_address_i, dfi_bank_i, dfi_cs_n_i, dfi_ras_n_i, dfi_cas_n_i, dfi_we_n_i,
           dfi_cke_i, dfi_reset_n_i, dfi_odt_i, dfi_wrdata_i, dfi_wrdata_en_i,
           dfi_wrdata_mask_i, dfi_rddata_en_i,
    output dfi_rddata_o, dfi_rddata_valid_o, dfi_rddata_dnv_o
  );
endinterface

// File: rtl/ddr3_dfi_responder.sv
// DDR3 DFI responder: bank tracking, line-addressed memory, fixed RD_DELAY read return, sticky error code.
// No backpressure: commands that cannot be queued and beats without a queued address are dropped and flagged.
module resp_addr_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         empty,
  output logic         full
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  slots [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   cnt;

  assign head_dat = slots[rd_ptr];
  assign empty    = (cnt == '0);
  assign full     = (cnt == (PW+1)'(DEPTH));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) slots[wr_ptr] <= push_dat;
  end
endmodule

module ddr3_dfi_responder #(
  parameter int LINE_AW  = 10,
  parameter int RD_DELAY = 2,
  parameter int QDEPTH   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  ddr3_dfi_responder_if.slave  dfi,
  output logic [7:0]           bank_open_o,
  output logic                 err_o,
  output logic [2:0]           err_code_o
);
  localparam int WA = LINE_AW + 2;

  typedef enum logic [2:0] {
    CMD_MRS = 3'b000, CMD_REF = 3'b001, CMD_PRE = 3'b010, CMD_ACT = 3'b011,
    CMD_WR  = 3'b100, CMD_RD  = 3'b101, CMD_ZQ  = 3'b110, CMD_NOP = 3'b111
  } cmd_e;

  cmd_e               cmd;
  logic               cmd_vld, is_act, is_rd, is_wr, is_pre, is_ref, rw;
  logic [7:0]         open_r;
  logic [14:0]        row_r [8];
  logic               bank_is_open;
  logic [24:0]        line_full;
  logic [LINE_AW-1:0] line_idx;
  logic               unused_inputs;

  assign cmd          = cmd_e'({dfi.dfi_ras_n_i, dfi.dfi_cas_n_i, dfi.dfi_we_n_i});
  assign cmd_vld      = dfi.dfi_cke_i && dfi.dfi_reset_n_i && !dfi.dfi_cs_n_i;
  assign is_act       = cmd_vld && (cmd == CMD_ACT);
  assign is_rd        = cmd_vld && (cmd == CMD_RD);
  assign is_wr        = cmd_vld && (cmd == CMD_WR);
  assign is_pre       = cmd_vld && (cmd == CMD_PRE);
  assign is_ref       = cmd_vld && (cmd == CMD_REF);
  assign rw           = is_rd || is_wr;
  assign bank_is_open = open_r[dfi.dfi_bank_i];
  assign unused_inputs = dfi.dfi_odt_i;

  // Column bits [2:0] select the beat within a burst, so they never reach the line index.
  assign line_full = {dfi.dfi_bank_i, row_r[dfi.dfi_bank_i], dfi.dfi_address_i[9:3]};
  assign line_idx  = LINE_AW'(line_full);

  logic               wq_push, wq_pop, wq_empty, wq_full;
  logic               rq_push, rq_pop, rq_empty, rq_full;
  logic [LINE_AW-1:0] wq_head, rq_head;
  logic [1:0]         wbeat, rbeat;
  logic               wr_acc, rd_acc;

  assign wr_acc  = dfi.dfi_wrdata_en_i && !wq_empty;
  assign rd_acc  = dfi.dfi_rddata_en_i && !rq_empty;
  assign wq_pop  = wr_acc && (wbeat == 2'd3);
  assign rq_pop  = rd_acc && (rbeat == 2'd3);
  assign wq_push = is_wr && bank_is_open && (!wq_full || wq_pop);
  assign rq_push = is_rd && bank_is_open && (!rq_full || rq_pop);

  resp_addr_fifo #(.W(LINE_AW), .DEPTH(QDEPTH)) u_wq (
    .clk_i(clk_i), .rst_i(rst_i), .push(wq_push), .push_dat(line_idx),
    .pop(wq_pop), .head_dat(wq_head), .empty(wq_empty), .full(wq_full)
  );

  resp_addr_fifo #(.W(LINE_AW), .DEPTH(QDEPTH)) u_rq (
    .clk_i(clk_i), .rst_i(rst_i), .push(rq_push), .push_dat(line_idx),
    .pop(rq_pop), .head_dat(rq_head), .empty(rq_empty), .full(rq_full)
  );

  logic [2:0] err_nxt;

  always_comb begin
    err_nxt = 3'd0;
    if (rw && !bank_is_open)                                                 err_nxt = 3'd1;
    else if (is_act && bank_is_open)                                         err_nxt = 3'd2;
    else if (is_ref && (|open_r))                                            err_nxt = 3'd3;
    else if (dfi.dfi_wrdata_en_i && wq_empty)                                err_nxt = 3'd4;
    else if (dfi.dfi_rddata_en_i && rq_empty)                                err_nxt = 3'd5;
    else if ((is_wr && wq_full && !wq_pop) || (is_rd && rq_full && !rq_pop)) err_nxt = 3'd6;
    else if (rw && (dfi.dfi_address_i[2:0] != 3'd0))                         err_nxt = 3'd7;
  end

  logic              rd_ok_q;
  logic [RD_DELAY-1:0] vld_pipe;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      open_r     <= '0;
      for (int b = 0; b < 8; b++) row_r[b] <= '0;
      wbeat      <= '0;
      rbeat      <= '0;
      err_o      <= 1'b0;
      err_code_o <= '0;
      rd_ok_q    <= 1'b0;
      vld_pipe   <= '0;
    end else begin
      if (is_act) begin
        open_r[dfi.dfi_bank_i] <= 1'b1;
        row_r[dfi.dfi_bank_i]  <= dfi.dfi_address_i;
      end else if (is_pre) begin
        if (dfi.dfi_address_i[10]) open_r <= '0;
        else                       open_r[dfi.dfi_bank_i] <= 1'b0;
      end
      if (wr_acc) wbeat <= wbeat + 2'd1;
      if (rd_acc) rbeat <= rbeat + 2'd1;
      if (!err_o && (err_nxt != 3'd0)) begin
        err_o      <= 1'b1;
        err_code_o <= err_nxt;
      end
      rd_ok_q     <= rd_acc;
      vld_pipe[0] <= dfi.dfi_rddata_en_i;
      for (int k = 1; k < RD_DELAY; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  assign bank_open_o = open_r;

  // Memory is not reset; a same-cycle write and read of one word returns the old word.
  logic [31:0] mem [2**WA];
  logic [31:0] mem_q;
  logic [WA-1:0] waddr, raddr;

  assign waddr = {wq_head, wbeat};
  assign raddr = {rq_head, rbeat};

  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      for (int i = 0; i < 4; i++) begin
        if (!dfi.dfi_wrdata_mask_i[i]) mem[waddr][8*i +: 8] <= dfi.dfi_wrdata_i[8*i +: 8];
      end
    end
    mem_q <= mem[raddr];
  end

  logic [31:0] stage0;
  assign stage0 = rd_ok_q ? mem_q : 32'd0;

  generate
    if (RD_DELAY == 1) begin : g_d1
      assign dfi.dfi_rddata_o = stage0;
    end else begin : g_dn
      logic [31:0] dp [RD_DELAY-1];
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int k = 0; k < RD_DELAY-1; k++) dp[k] <= '0;
        end else begin
          dp[0] <= stage0;
          for (int k = 1; k < RD_DELAY-1; k++) dp[k] <= dp[k-1];
        end
      end
      assign dfi.dfi_rddata_o = dp[RD_DELAY-2];
    end
  endgenerate

  assign dfi.dfi_rddata_valid_o = vld_pipe[RD_DELAY-1];
  assign dfi.dfi_rddata_dnv_o   = 2'b00;
endmodule
